ex_mem_reg: RTL and testbench

//  EX/MEM pipeline register of the pipelined CPU; sits between the EX stage (ALU, branch adder) and the MEM stage.

---
 rtl/ex_mem_reg.sv | 145 ++++++++++++++
 tb/tb_ex_mem_reg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// ============================================================================
// ex_mem_reg
// ----------------------------------------------------------------------------
// EX/MEM pipeline register of the pipelined CPU. It sits between the EX stage
// (ALU, branch adder) and the MEM stage. Every rising edge it either clears
// itself (reset), inserts a bubble (flush), holds (stall), or captures the EX
// slot. Control bits are cleaned up on capture so the MEM and WB stages never
// see impossible or harmful combinations. A saturating counter records how many
// bubbles have entered MEM since reset, for pipeline debug.
//
// Parameters
//   DATA_W  width of alu_res, RtData and the branch target
//   REG_AW  register-file address width
//   CNT_W   width of bubble_cnt
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   stall                   hold every register this cycle
//   flush                   load a bubble this cycle (wins over stall)
//   valid_ex                EX slot holds a real instruction
//   RegWrite_ex ..          EX-stage control: RegWrite, MemtoReg, MemRead,
//     Branch_ex             MemWrite, Branch
//   alu_zero_ex             ALU zero flag
//   alu_res_ex, RtData_ex   ALU result / address and store data
//   WriteReg_ex             destination register
//   branch_pc_ex            branch target address
//   valid_mem, *_mem        registered copies driving the MEM/WB stages
//   fwd_we_mem              the MEM slot may forward alu_res to EX
//   bubble_cnt              bubbles inserted since reset, saturating
// ============================================================================
module ex_mem_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_ex,
    input  logic              RegWrite_ex,
    input  logic              MemtoReg_ex,
    input  logic              MemRead_ex,
    input  logic              MemWrite_ex,
    input  logic              Branch_ex,
    input  logic              alu_zero_ex,
    input  logic [DATA_W-1:0] alu_res_ex,
    input  logic [DATA_W-1:0] RtData_ex,
    input  logic [REG_AW-1:0] WriteReg_ex,
    input  logic [DATA_W-1:0] branch_pc_ex,
    output logic              valid_mem,
    output logic              RegWrite_mem,
    output logic              MemtoReg_mem,
    output logic              MemRead_mem,
    output logic              MemWrite_mem,
    output logic              Branch_mem,
    output logic              alu_zero_mem,
    output logic [DATA_W-1:0] alu_res_mem,
    output logic [DATA_W-1:0] RtData_mem,
    output logic [REG_AW-1:0] WriteReg_mem,
    output logic [DATA_W-1:0] branch_pc_mem,
    output logic              fwd_we_mem,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Sanitised control values that would be captured on a normal load.
    logic ld_reg_write;
    logic ld_memto_reg;
    logic ld_mem_read;
    logic ld_mem_write;
    logic ld_branch;
    logic ld_alu_zero;

    // Bubble bookkeeping.
    logic bubble_in;
    logic cnt_sat;

    // Control clean-up applied on capture. An empty EX slot carries no
    // side effects, a load+store combination degrades to a plain load so
    // data memory is never written by it, and writes to register $zero are
    // dropped here so the forwarding unit never sees them either.
    always_comb begin
        ld_reg_write = valid_ex & RegWrite_ex & (WriteReg_ex != '0);
        ld_memto_reg = valid_ex & MemtoReg_ex;
        ld_mem_read  = valid_ex & MemRead_ex;
        ld_mem_write = valid_ex & MemWrite_ex & ~MemRead_ex;
        ld_branch    = valid_ex & Branch_ex;
        ld_alu_zero  = valid_ex & alu_zero_ex;
    end

    // A bubble enters MEM on a flush (even when stalled), or on an unstalled
    // load of an empty EX slot. The counter stops at all-ones.
    always_comb begin
        bubble_in = flush | (~stall & ~valid_ex);
        cnt_sat   = &bubble_cnt;
    end

    // Pipeline slot register: reset and flush both clear the whole slot,
    // data included, so a bubble is indistinguishable from the reset state.
    // A stall simply leaves every flop untouched.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_mem     <= 1'b0;
            RegWrite_mem  <= 1'b0;
            MemtoReg_mem  <= 1'b0;
            MemRead_mem   <= 1'b0;
            MemWrite_mem  <= 1'b0;
            Branch_mem    <= 1'b0;
            alu_zero_mem  <= 1'b0;
            alu_res_mem   <= '0;
            RtData_mem    <= '0;
            WriteReg_mem  <= '0;
            branch_pc_mem <= '0;
        end else if (!stall) begin
            valid_mem     <= valid_ex;
            RegWrite_mem  <= ld_reg_write;
            MemtoReg_mem  <= ld_memto_reg;
            MemRead_mem   <= ld_mem_read;
            MemWrite_mem  <= ld_mem_write;
            Branch_mem    <= ld_branch;
            alu_zero_mem  <= ld_alu_zero;
            alu_res_mem   <= alu_res_ex;
            RtData_mem    <= RtData_ex;
            WriteReg_mem  <= WriteReg_ex;
            branch_pc_mem <= branch_pc_ex;
        end
    end

    // Debug bubble counter, cleared by reset and otherwise only stepped
    // when a bubble actually enters the MEM slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (bubble_in && !cnt_sat) begin
            bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Forwarding from MEM is only legal for a real ALU result headed for the
    // register file; load data is not available yet at this point.
    always_comb begin
        fwd_we_mem = valid_mem & RegWrite_mem & ~MemtoReg_mem;
    end

endmodule

// File: tb/tb_ex_mem_reg.sv
// ============================================================================
// tb_ex_mem_reg
// ----------------------------------------------------------------------------
// Bench for ex_mem_reg. Two instances share the same stimulus: one with the
// default 16-bit bubble counter and one with a 4-bit counter so saturation is
// reachable quickly. A behavioural model tracks what the MEM slot must hold
// and how many bubbles have entered it; a compare process checks both DUTs
// against it every cycle, and directed sequences pin literal values.
// ============================================================================
module tb_ex_mem_reg;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        valid_ex;
    logic        RegWrite_ex;
    logic        MemtoReg_ex;
    logic        MemRead_ex;
    logic        MemWrite_ex;
    logic        Branch_ex;
    logic        alu_zero_ex;
    logic [31:0] alu_res_ex;
    logic [31:0] RtData_ex;
    logic [4:0]  WriteReg_ex;
    logic [31:0] branch_pc_ex;

    logic        valid_mem,  valid_mem4;
    logic        RegWrite_mem, RegWrite_mem4;
    logic        MemtoReg_mem, MemtoReg_mem4;
    logic        MemRead_mem, MemRead_mem4;
    logic        MemWrite_mem, MemWrite_mem4;
    logic        Branch_mem, Branch_mem4;
    logic        alu_zero_mem, alu_zero_mem4;
    logic [31:0] alu_res_mem, alu_res_mem4;
    logic [31:0] RtData_mem, RtData_mem4;
    logic [4:0]  WriteReg_mem, WriteReg_mem4;
    logic [31:0] branch_pc_mem, branch_pc_mem4;
    logic        fwd_we_mem, fwd_we_mem4;
    logic [15:0] bubble_cnt;
    logic [3:0]  bubble_cnt4;

    int check_count = 0;
    int pass_count  = 0;
    bit check_en    = 0;

    // Reference model of the MEM slot and the bubble total.
    logic        m_valid, m_rw, m_m2r, m_mr, m_mw, m_br, m_z;
    logic [31:0] m_alu, m_rt, m_bpc;
    logic [4:0]  m_wr;
    int unsigned m_bubbles;

    ex_mem_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_ex(valid_ex), .RegWrite_ex(RegWrite_ex), .MemtoReg_ex(MemtoReg_ex),
        .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex), .Branch_ex(Branch_ex),
        .alu_zero_ex(alu_zero_ex), .alu_res_ex(alu_res_ex), .RtData_ex(RtData_ex),
        .WriteReg_ex(WriteReg_ex), .branch_pc_ex(branch_pc_ex),
        .valid_mem(valid_mem), .RegWrite_mem(RegWrite_mem), .MemtoReg_mem(MemtoReg_mem),
        .MemRead_mem(MemRead_mem), .MemWrite_mem(MemWrite_mem), .Branch_mem(Branch_mem),
        .alu_zero_mem(alu_zero_mem), .alu_res_mem(alu_res_mem), .RtData_mem(RtData_mem),
        .WriteReg_mem(WriteReg_mem), .branch_pc_mem(branch_pc_mem),
        .fwd_we_mem(fwd_we_mem), .bubble_cnt(bubble_cnt)
    );

    ex_mem_reg #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_ex(valid_ex), .RegWrite_ex(RegWrite_ex), .MemtoReg_ex(MemtoReg_ex),
        .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex), .Branch_ex(Branch_ex),
        .alu_zero_ex(alu_zero_ex), .alu_res_ex(alu_res_ex), .RtData_ex(RtData_ex),
        .WriteReg_ex(WriteReg_ex), .branch_pc_ex(branch_pc_ex),
        .valid_mem(valid_mem4), .RegWrite_mem(RegWrite_mem4), .MemtoReg_mem(MemtoReg_mem4),
        .MemRead_mem(MemRead_mem4), .MemWrite_mem(MemWrite_mem4), .Branch_mem(Branch_mem4),
        .alu_zero_mem(alu_zero_mem4), .alu_res_mem(alu_res_mem4), .RtData_mem(RtData_mem4),
        .WriteReg_mem(WriteReg_mem4), .branch_pc_mem(branch_pc_mem4),
        .fwd_we_mem(fwd_we_mem4), .bubble_cnt(bubble_cnt4)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one full input vector, then let one rising edge consume it and
    // return shortly after that edge so the new outputs are visible.
    task automatic applyStimulus(
        input logic rst, input logic st, input logic fl, input logic v,
        input logic rw, input logic m2r, input logic mr, input logic mw,
        input logic br, input logic z, input logic [31:0] alu,
        input logic [31:0] rt, input logic [4:0] wr, input logic [31:0] bpc);
        reset = rst; stall = st; flush = fl; valid_ex = v;
        RegWrite_ex = rw; MemtoReg_ex = m2r; MemRead_ex = mr; MemWrite_ex = mw;
        Branch_ex = br; alu_zero_ex = z; alu_res_ex = alu; RtData_ex = rt;
        WriteReg_ex = wr; branch_pc_ex = bpc;
        @(posedge clk);
        #1;
    endtask

    // Model update: describes what MEM must hold after each edge in terms of
    // the slot's meaning, not the register structure.
    always @(posedge clk) begin
        if (reset) begin
            {m_valid, m_rw, m_m2r, m_mr, m_mw, m_br, m_z} = '0;
            m_alu = 0; m_rt = 0; m_bpc = 0; m_wr = 0;
            m_bubbles = 0;
        end else if (flush) begin
            {m_valid, m_rw, m_m2r, m_mr, m_mw, m_br, m_z} = '0;
            m_alu = 0; m_rt = 0; m_bpc = 0; m_wr = 0;
            m_bubbles = m_bubbles + 1;
        end else if (!stall) begin
            m_valid = valid_ex;
            if (valid_ex) begin
                m_mr  = MemRead_ex;
                m_mw  = MemRead_ex ? 1'b0 : MemWrite_ex;
                m_rw  = (WriteReg_ex == 5'd0) ? 1'b0 : RegWrite_ex;
                m_m2r = MemtoReg_ex;
                m_br  = Branch_ex;
                m_z   = alu_zero_ex;
            end else begin
                {m_rw, m_m2r, m_mr, m_mw, m_br, m_z} = '0;
                m_bubbles = m_bubbles + 1;
            end
            m_alu = alu_res_ex; m_rt = RtData_ex; m_bpc = branch_pc_ex; m_wr = WriteReg_ex;
        end
    end

    // Per-cycle comparison of both DUTs against the model, sampled on the
    // falling edge well away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            logic [108:0] exp_v;
            logic         exp_fwd;
            exp_fwd = m_valid && m_rw && !m_m2r;
            exp_v = {m_valid, m_rw, m_m2r, m_mr, m_mw, m_br, m_z, exp_fwd, m_wr, m_alu, m_rt, m_bpc};
            checkOutput("slot16", {valid_mem, RegWrite_mem, MemtoReg_mem, MemRead_mem,
                                   MemWrite_mem, Branch_mem, alu_zero_mem, fwd_we_mem,
                                   WriteReg_mem, alu_res_mem, RtData_mem, branch_pc_mem}, exp_v);
            checkOutput("slot4", {valid_mem4, RegWrite_mem4, MemtoReg_mem4, MemRead_mem4,
                                  MemWrite_mem4, Branch_mem4, alu_zero_mem4, fwd_we_mem4,
                                  WriteReg_mem4, alu_res_mem4, RtData_mem4, branch_pc_mem4}, exp_v);
            checkOutput("bubble16", bubble_cnt, (m_bubbles > 65535) ? 65535 : m_bubbles);
            checkOutput("bubble4", bubble_cnt4, (m_bubbles > 15) ? 15 : m_bubbles);
        end
    end

    // Directed sequences with literal expectations, then a random run.
    initial begin
        $display("[TB] start");

        // Reset held two cycles with every input high.
        applyStimulus(1,1,1,1, 1,1,1,1, 1,1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F, 32'hFFFF_FFFF);
        check_en = 1;
        applyStimulus(1,1,1,1, 1,1,1,1, 1,1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F, 32'hFFFF_FFFF);
        checkOutput("reset_valid", valid_mem, 0);
        checkOutput("reset_alu", alu_res_mem, 0);
        checkOutput("reset_ctrl", {RegWrite_mem, MemtoReg_mem, MemRead_mem, MemWrite_mem, Branch_mem, alu_zero_mem, fwd_we_mem}, 0);
        checkOutput("reset_cnt", bubble_cnt, 0);

        // Plain ALU load.
        applyStimulus(0,0,0,1, 1,0,0,0, 0,0, 32'h0000_0010, 32'hDEAD_BEEF, 5'd8, 32'h0000_0100);
        checkOutput("load_alu", alu_res_mem, 32'h10);
        checkOutput("load_rt", RtData_mem, 32'hDEAD_BEEF);
        checkOutput("load_wr", WriteReg_mem, 8);
        checkOutput("load_fwd", fwd_we_mem, 1);

        // Stall for three cycles with different inputs.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0,1,0,0, 0,0,1,1, 1,1, 32'h44, 32'h1234, 5'd9, 32'h200);
            checkOutput("stall_alu", alu_res_mem, 32'h10);
            checkOutput("stall_cnt", bubble_cnt, 0);
        end

        // Flush beats stall on a captured store.
        applyStimulus(0,0,0,1, 0,0,0,1, 0,0, 32'h80, 32'h55, 5'd0, 32'h300);
        checkOutput("store_mw", MemWrite_mem, 1);
        applyStimulus(0,1,1,1, 1,0,0,1, 0,0, 32'h90, 32'h66, 5'd4, 32'h400);
        checkOutput("flush_mw", MemWrite_mem, 0);
        checkOutput("flush_valid", valid_mem, 0);
        checkOutput("flush_alu", alu_res_mem, 0);
        checkOutput("flush_cnt", bubble_cnt, 1);

        // Sanitisation of load+store and writes to $zero.
        applyStimulus(0,0,0,1, 1,1,1,1, 0,0, 32'hA0, 32'h77, 5'd3, 32'h500);
        checkOutput("san_mw", MemWrite_mem, 0);
        checkOutput("san_mr", MemRead_mem, 1);
        applyStimulus(0,0,0,1, 1,0,0,0, 1,1, 32'hB0, 32'h88, 5'd0, 32'h600);
        checkOutput("san_rw", RegWrite_mem, 0);
        checkOutput("san_fwd", fwd_we_mem, 0);
        checkOutput("san_br", Branch_mem, 1);

        // Saturation of the 4-bit counter over 20 empty loads.
        applyStimulus(1,0,0,0, 0,0,0,0, 0,0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0,0,0,0, 1,1,1,1, 1,1, 32'hC0 + i, 32'h99, 5'd7, 32'h700);
        end
        checkOutput("sat_cnt4", bubble_cnt4, 4'hF);
        checkOutput("sat_cnt16", bubble_cnt, 20);
        checkOutput("empty_ctrl", {RegWrite_mem, MemRead_mem, MemWrite_mem, Branch_mem}, 0);
        checkOutput("empty_alu", alu_res_mem, 32'hC0 + 19);

        // Randomised traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            logic [4:0] wr;
            wr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 4) == 0,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 3) != 0,
                          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom),
                          $urandom, $urandom, wr, $urandom);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
